// File: rtl/store_align_buffer.sv
// Store-side alignment buffer: checks store legality, lane-aligns data and strobes,
// and queues word-aligned writes in a small FIFO that drains to the data memory.
module store_align_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        StoreTypeM,
  input  logic              store_valid,
  output logic              store_ready,
  input  logic [XLEN-1:0]   store_addr,
  input  logic [XLEN-1:0]   store_data,
  output logic              store_err,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [XLEN-1:0]   mem_waddr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              ld_chk_valid,
  input  logic [XLEN-1:0]   ld_chk_addr,
  output logic              ld_conflict,
  output logic              empty
);

  localparam int STRBW = XLEN / 8;
  localparam int OFFW  = $clog2(STRBW);
  localparam int PTRW  = $clog2(DEPTH);
  localparam int CNTW  = PTRW + 1;
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(STRBW - 1);

  logic [XLEN-1:0]  addrMem_q [DEPTH];
  logic [XLEN-1:0]  dataMem_q [DEPTH];
  logic [STRBW-1:0] strbMem_q [DEPTH];

  logic [PTRW-1:0] wptr_q, wptr_d;
  logic [PTRW-1:0] rptr_q, rptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            err_q, err_d;

  logic [OFFW-1:0]  byteOff;
  logic [OFFW+2:0]  bitShift;
  logic             legal;
  logic [XLEN-1:0]  encData;
  logic [STRBW-1:0] encStrb;
  logic             accept, push, pop;
  logic [PTRW-1:0]  idx;
  logic             hit;

  assign byteOff  = store_addr[OFFW-1:0];
  assign bitShift = {byteOff, 3'b000};

  always_comb begin
    legal   = 1'b0;
    encData = '0;
    encStrb = '0;
    case (StoreTypeM)
      3'b000: begin
        legal   = 1'b1;
        encData = XLEN'(store_data[7:0]) << bitShift;
        encStrb = STRBW'(1) << byteOff;
      end
      3'b001: begin
        legal   = ~byteOff[0];
        encData = XLEN'(store_data[15:0]) << bitShift;
        encStrb = STRBW'(2'b11) << byteOff;
      end
      3'b010: begin
        legal   = (byteOff[1:0] == 2'b00);
        encData = XLEN'(store_data[31:0]) << bitShift;
        encStrb = STRBW'(4'b1111) << byteOff;
      end
      default: legal = 1'b0;
    endcase
  end

  assign empty       = (count_q == '0);
  assign store_ready = (count_q != CNTW'(DEPTH));
  assign mem_wvalid  = ~empty;
  assign accept      = store_valid & store_ready;
  assign push        = accept & legal;
  assign pop         = mem_wvalid & mem_wready;
  assign store_err   = err_q;

  always_comb begin
    wptr_d  = wptr_q + PTRW'(push);
    rptr_d  = rptr_q + PTRW'(pop);
    count_d = count_q + CNTW'(push) - CNTW'(pop);
    err_d   = accept & ~legal;
  end

  // Payload storage is left unreset; the head outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (push) begin
        addrMem_q[wptr_q] <= store_addr & WORD_MASK;
        dataMem_q[wptr_q] <= encData;
        strbMem_q[wptr_q] <= encStrb;
      end
    end
  end

  assign mem_waddr = empty ? '0 : addrMem_q[rptr_q];
  assign mem_wdata = empty ? '0 : dataMem_q[rptr_q];
  assign mem_wstrb = empty ? '0 : strbMem_q[rptr_q];

  // Only occupied slots, counted from the head, take part in the load check.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr_q + PTRW'(i);
      if ((CNTW'(i) < count_q) && (addrMem_q[idx] == (ld_chk_addr & WORD_MASK)))
        hit = 1'b1;
    end
  end

  assign ld_conflict = ld_chk_valid & hit;

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed bench for store_align_buffer: vector table for single stores plus
// hand-written sequences for backpressure, wrap, load conflicts and reset.
module tb_store_align_buffer;

  logic        clk;
  logic        rst_n;
  logic [2:0]  StoreTypeM;
  logic        store_valid;
  logic        store_ready;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic        store_err;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        ld_chk_valid;
  logic [31:0] ld_chk_addr;
  logic        ld_conflict;
  logic        empty;

  int checks;
  int failures;

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
    logic        expErr;
    logic [31:0] expAddr;
    logic [31:0] expData;
    logic [3:0]  expStrb;
  } vec_t;

  vec_t vecs[12];
  int   h;

  store_align_buffer #(.XLEN(32), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .StoreTypeM   (StoreTypeM),
    .store_valid  (store_valid),
    .store_ready  (store_ready),
    .store_addr   (store_addr),
    .store_data   (store_data),
    .store_err    (store_err),
    .mem_wvalid   (mem_wvalid),
    .mem_wready   (mem_wready),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .ld_chk_valid (ld_chk_valid),
    .ld_chk_addr  (ld_chk_addr),
    .ld_conflict  (ld_conflict),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] data);
    StoreTypeM  = typ;
    store_addr  = addr;
    store_data  = data;
    store_valid = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    StoreTypeM = 3'b000;
    store_valid = 1'b0;
    store_addr = '0;
    store_data = '0;
    mem_wready = 1'b0;
    ld_chk_valid = 1'b0;
    ld_chk_addr = '0;

    vecs[0]  = '{3'b000, 32'h0000_1003, 32'h0000_00AB, 1'b0, 32'h0000_1000, 32'hAB00_0000, 4'b1000};
    vecs[1]  = '{3'b001, 32'h0000_2002, 32'h1234_CDEF, 1'b0, 32'h0000_2000, 32'hCDEF_0000, 4'b1100};
    vecs[2]  = '{3'b010, 32'h0000_2006, 32'h1234_CDEF, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[3]  = '{3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111};
    vecs[4]  = '{3'b000, 32'h0000_0010, 32'hFFFF_FF5A, 1'b0, 32'h0000_0010, 32'h0000_005A, 4'b0001};
    vecs[5]  = '{3'b000, 32'h0000_0005, 32'h0000_0077, 1'b0, 32'h0000_0004, 32'h0000_7700, 4'b0010};
    vecs[6]  = '{3'b001, 32'h0000_0008, 32'hAAAA_5555, 1'b0, 32'h0000_0008, 32'h0000_5555, 4'b0011};
    vecs[7]  = '{3'b001, 32'h0000_0009, 32'hAAAA_5555, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[8]  = '{3'b011, 32'h0000_0000, 32'h1111_2222, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[9]  = '{3'b100, 32'h0000_0000, 32'h1111_2222, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[10] = '{3'b010, 32'h0000_0007, 32'h1111_2222, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[11] = '{3'b000, 32'h0000_0002, 32'hFFFF_FF12, 1'b0, 32'h0000_0000, 32'h0012_0000, 4'b0100};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_wvalid", 32'(mem_wvalid), 32'd0);
    checkOutput("rst_ready", 32'(store_ready), 32'd1);
    checkOutput("rst_err", 32'(store_err), 32'd0);
    checkOutput("rst_waddr", mem_waddr, 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_wstrb", 32'(mem_wstrb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single stores, each drained the cycle after it appears at the head.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].typ, vecs[i].addr, vecs[i].data);
      mem_wready = 1'b1;
      @(posedge clk);
      #1;
      store_valid = 1'b0;
      checkOutput($sformatf("vec%0d_err", i), 32'(store_err), 32'(vecs[i].expErr));
      if (vecs[i].expErr) begin
        checkOutput($sformatf("vec%0d_empty", i), 32'(empty), 32'd1);
      end else begin
        checkOutput($sformatf("vec%0d_wvalid", i), 32'(mem_wvalid), 32'd1);
        checkOutput($sformatf("vec%0d_waddr", i), mem_waddr, vecs[i].expAddr);
        checkOutput($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].expData);
        checkOutput($sformatf("vec%0d_wstrb", i), 32'(mem_wstrb), 32'(vecs[i].expStrb));
      end
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_drained", i), 32'(empty), 32'd1);
      checkOutput($sformatf("vec%0d_errclr", i), 32'(store_err), 32'd0);
    end

    // Backpressure: fill, block the fifth store, then drain in order.
    @(negedge clk);
    mem_wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_ready%0d", i), 32'(store_ready), 32'd1);
      applyStimulus(3'b010, 32'(4 * i), 32'h1111_0000 + 32'(i));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    applyStimulus(3'b010, 32'h10, 32'h1111_0004);
    checkOutput("bp_full", 32'(store_ready), 32'd0);
    checkOutput("bp_head_addr", mem_waddr, 32'h0);
    checkOutput("bp_head_data", mem_wdata, 32'h1111_0000);
    @(posedge clk);
    #1;
    checkOutput("bp_stable_addr", mem_waddr, 32'h0);
    checkOutput("bp_stable_data", mem_wdata, 32'h1111_0000);
    checkOutput("bp_still_full", 32'(store_ready), 32'd0);
    @(negedge clk);
    mem_wready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_pop0", mem_waddr, 32'h4);
    checkOutput("bp_slot_free", 32'(store_ready), 32'd1);
    @(posedge clk);
    #1;
    store_valid = 1'b0;
    checkOutput("bp_pop1", mem_waddr, 32'h8);
    @(posedge clk);
    #1;
    checkOutput("bp_pop2", mem_waddr, 32'hC);
    @(posedge clk);
    #1;
    checkOutput("bp_fifth_addr", mem_waddr, 32'h10);
    checkOutput("bp_fifth_data", mem_wdata, 32'h1111_0004);
    @(posedge clk);
    #1;
    checkOutput("bp_empty", 32'(empty), 32'd1);

    // Full with a pending pop: no accept that edge, then steady accept+pop with wrap.
    @(negedge clk);
    mem_wready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      applyStimulus(3'b010, 32'h100 + 32'(4 * j), 32'hC0DE_0000 + 32'(j));
      @(posedge clk);
      #1;
    end
    checkOutput("wrap_full", 32'(store_ready), 32'd0);
    @(negedge clk);
    applyStimulus(3'b010, 32'h110, 32'hC0DE_0004);
    mem_wready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("wrap_no_accept", 32'(store_ready), 32'd1);
    checkOutput("wrap_head1", mem_waddr, 32'h104);
    h = 1;
    for (int j = 4; j < 14; j++) begin
      @(posedge clk);
      #1;
      h++;
      checkOutput($sformatf("wrap_addr%0d", j), mem_waddr, 32'h100 + 32'(4 * h));
      checkOutput($sformatf("wrap_data%0d", j), mem_wdata, 32'hC0DE_0000 + 32'(h));
      checkOutput($sformatf("wrap_ready%0d", j), 32'(store_ready), 32'd1);
      if (j < 13) applyStimulus(3'b010, 32'h100 + 32'(4 * (j + 1)), 32'hC0DE_0000 + 32'(j + 1));
      else store_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput("wrap_tail12", mem_waddr, 32'h130);
    @(posedge clk);
    #1;
    checkOutput("wrap_tail13", mem_waddr, 32'h134);
    checkOutput("wrap_tail13_strb", 32'(mem_wstrb), 32'hF);
    @(posedge clk);
    #1;
    checkOutput("wrap_empty", 32'(empty), 32'd1);

    // Load conflict against a queued byte store.
    @(negedge clk);
    mem_wready = 1'b0;
    applyStimulus(3'b000, 32'h3001, 32'h99);
    ld_chk_valid = 1'b1;
    ld_chk_addr = 32'h3003;
    #1;
    checkOutput("ld_accepting", 32'(ld_conflict), 32'd0);
    @(posedge clk);
    #1;
    store_valid = 1'b0;
    #1;
    checkOutput("ld_hit", 32'(ld_conflict), 32'd1);
    ld_chk_addr = 32'h3004;
    #1;
    checkOutput("ld_other_word", 32'(ld_conflict), 32'd0);
    ld_chk_valid = 1'b0;
    ld_chk_addr = 32'h3003;
    #1;
    checkOutput("ld_not_valid", 32'(ld_conflict), 32'd0);
    ld_chk_valid = 1'b1;
    mem_wready = 1'b1;
    #1;
    checkOutput("ld_popping", 32'(ld_conflict), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("ld_after_pop", 32'(ld_conflict), 32'd0);
    ld_chk_valid = 1'b0;

    // Illegal funct3, then reset with three entries queued.
    @(negedge clk);
    applyStimulus(3'b011, 32'h40, 32'h5);
    @(posedge clk);
    #1;
    store_valid = 1'b0;
    checkOutput("ill_err", 32'(store_err), 32'd1);
    checkOutput("ill_empty", 32'(empty), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("ill_errclr", 32'(store_err), 32'd0);
    @(negedge clk);
    mem_wready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      applyStimulus(3'b010, 32'h50 + 32'(4 * j), 32'hFACE_0000 + 32'(j));
      @(posedge clk);
      #1;
    end
    checkOutput("rq_wvalid", 32'(mem_wvalid), 32'd1);
    checkOutput("rq_ready", 32'(store_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(3'b011, 32'h60, 32'h0);
    mem_wready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rq_empty", 32'(empty), 32'd1);
    checkOutput("rq_wvalid0", 32'(mem_wvalid), 32'd0);
    checkOutput("rq_ready1", 32'(store_ready), 32'd1);
    checkOutput("rq_err0", 32'(store_err), 32'd0);
    checkOutput("rq_waddr0", mem_waddr, 32'd0);
    checkOutput("rq_wstrb0", 32'(mem_wstrb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    store_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rq_stay_empty", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
